// File: rtl/ahb_lite_cmd_master.sv
// ----------------------------------------------------------------------------
// ahb_lite_cmd_master
//
// Purpose
//   Turns a valid/ready command stream into pipelined single (NONSEQ)
//   AHB-Lite transfers for the debug/test memory path. The design has two
//   pipeline slots:
//     A - address phase. It drives HADDR/HWRITE/HSIZE/HTRANS/HSEL.
//     D - data phase. It drives HWDATA and waits for HREADY.
//   Every accepted command produces exactly one response, in command order.
//   The two-cycle HRESP error response cancels the command waiting in A.
//   A wait-state watchdog ends a data phase that never completes and then
//   marks the bus as hung.
//
// Handshakes
//   A command transfers on a rising edge where cmd_valid & cmd_ready are both
//   high. cmd_* must be held stable while cmd_valid is high and cmd_ready is
//   low. rsp_valid is a one-cycle pulse. It cannot be back-pressured.
//
// Ports
//   HCLK, HRESET              clock; synchronous active-high reset
//   cmd_valid/ready           command handshake
//   cmd_write/addr/size/wdata command fields (addr, size passed through)
//   rsp_valid/write/rdata     response pulse, direction, read data
//   rsp_err/rsp_cancel        error flag; set with cancel when never issued
//   bus_hung                  sticky watchdog flag, cleared only by HRESET
//   HADDR..HWDATA             AHB-Lite master outputs (single slave, HSEL)
//   HRDATA/HREADY/HRESP       AHB-Lite slave responses
// ----------------------------------------------------------------------------
module ahb_lite_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_cancel,
   output logic        bus_hung,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [1:0]  HTRANS,
   output logic        HSEL,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam int WD_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   // When the watchdog is disabled this value is never used.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   // A slot
   logic            a_valid;
   logic [31:0]     a_wdata;
   // D slot
   logic            d_valid;
   logic            d_write;
   // A command that was cancelled. It responds the cycle after D responds.
   logic            cancel_pend;
   logic            cancel_write;
   logic            cancel_go;
   logic [WD_W-1:0] wd_cnt;

   logic accept;
   logic d_done;
   logic err1;
   logic timeout;

   // err1 marks the first cycle of the two-cycle error response.
   assign err1      = d_valid & HRESP & ~HREADY;
   assign d_done    = d_valid & HREADY;
   // timeout fires on the cycle that would be the TIMEOUT_CYCLES-th wait.
   assign timeout   = (TIMEOUT_CYCLES != 0) && d_valid && !HREADY && (wd_cnt == WD_LAST);
   assign cmd_ready = ~HRESET & ~bus_hung & ~err1 & (~a_valid | HREADY);
   assign accept    = cmd_valid & cmd_ready;

   assign HTRANS = {a_valid, 1'b0};
   assign HSEL   = a_valid;
   assign HBURST = 3'b000;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         a_valid      <= 1'b0;
         HADDR        <= '0;
         HWRITE       <= 1'b0;
         HSIZE        <= '0;
         a_wdata      <= '0;
         d_valid      <= 1'b0;
         d_write      <= 1'b0;
         HWDATA       <= '0;
         cancel_pend  <= 1'b0;
         cancel_write <= 1'b0;
         cancel_go    <= 1'b0;
         wd_cnt       <= '0;
         bus_hung     <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_write    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         rsp_cancel   <= 1'b0;
      end else begin
         rsp_valid  <= 1'b0;
         rsp_write  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         rsp_cancel <= 1'b0;

         if (d_valid && !HREADY) wd_cnt <= wd_cnt + 1'b1;
         else                    wd_cnt <= '0;

         if (timeout) begin
            // Abandon the stuck data phase. Any command still in A is
            // cancelled, and the master stops accepting until HRESET.
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_write <= d_write;
            d_valid   <= 1'b0;
            a_valid   <= 1'b0;
            bus_hung  <= 1'b1;
            wd_cnt    <= '0;
            if (a_valid) begin
               cancel_pend  <= 1'b1;
               cancel_write <= HWRITE;
            end
            cancel_go <= a_valid | cancel_pend;
         end else begin
            if (cancel_go) begin
               rsp_valid   <= 1'b1;
               rsp_err     <= 1'b1;
               rsp_cancel  <= 1'b1;
               rsp_write   <= cancel_write;
               cancel_go   <= 1'b0;
               cancel_pend <= 1'b0;
            end

            if (d_done) begin
               rsp_valid <= 1'b1;
               rsp_err   <= HRESP;
               rsp_write <= d_write;
               rsp_rdata <= (!d_write && !HRESP) ? HRDATA : 32'h0;
               if (cancel_pend) cancel_go <= 1'b1;
            end

            // A -> D. HWDATA keeps its last value across reads.
            if (HREADY) begin
               d_valid <= a_valid;
               if (a_valid) begin
                  d_write <= HWRITE;
                  if (HWRITE) HWDATA <= a_wdata;
               end
            end

            if (err1) begin
               // Drop the address phase now, so HTRANS is IDLE in the second
               // error cycle.
               a_valid <= 1'b0;
               if (a_valid) begin
                  cancel_pend  <= 1'b1;
                  cancel_write <= HWRITE;
               end
            end else if (!a_valid || HREADY) begin
               a_valid <= accept;
               if (accept) begin
                  HADDR   <= cmd_addr;
                  HWRITE  <= cmd_write;
                  HSIZE   <= cmd_size;
                  a_wdata <= cmd_wdata;
               end
            end
         end
      end
   end

endmodule
